// File: rtl/common_types_pkg.sv
// Types and constants shared by the GNSS sample capture path.
package common_types_pkg;

   localparam int CAPTURE_WORD_W = 32;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CAPTURE = 3'd1,
      ST_RD_ADDR = 3'd2,
      ST_RD_WAIT = 3'd3,
      ST_SEND    = 3'd4,
      ST_DONE    = 3'd5
   } capture_state_t;

   function automatic int samples_per_word(input int channels, input int sample_bits);
      return CAPTURE_WORD_W / (channels * sample_bits);
   endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
module capture_ram
   import common_types_pkg::*;
#(
   parameter int DEPTH  = 24000,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int WIDTH  = CAPTURE_WORD_W
) (
   input  logic              clk,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [WIDTH-1:0]  wr_data_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [WIDTH-1:0]  rd_data_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // No reset on the array or read register so the tools map this onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
      if (rd_en_i) begin
         rd_data_o <= mem_q[rd_addr_i];
      end
   end

endmodule

// File: rtl/gnss_capture_buffer.sv
// Packs front-end sign/magnitude samples into 32-bit words, stores them one-shot or
// as a ring, then drains the captured words as a little-endian byte stream.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | nothing armed; waits for start
// ST_CAPTURE | shifting samples in, writing completed words to RAM
// ST_RD_ADDR | read address presented to RAM
// ST_RD_WAIT | RAM read latency; word loaded into output register at exit
// ST_SEND    | presenting bytes 0..3 of the current word
// ST_DONE    | dump complete; done held high until start
module gnss_capture_buffer
   import common_types_pkg::*;
#(
   parameter  int CHANNELS    = 2,
   parameter  int SAMPLE_BITS = 2,
   parameter  int DEPTH       = 24000,
   localparam int ADDR_W      = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cfg_mode,
   input  logic [ADDR_W:0]        cfg_words,
   input  logic                   start,
   input  logic                   stop,
   input  logic                   smp_valid,
   input  logic [SAMPLE_BITS-1:0] smp_i,
   input  logic [SAMPLE_BITS-1:0] smp_q,
   output logic [7:0]             out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_last,
   output logic                   busy,
   output logic                   done,
   output logic                   wrapped
);

   localparam int CW    = CHANNELS * SAMPLE_BITS;
   localparam int SPW   = samples_per_word(CHANNELS, SAMPLE_BITS);
   localparam int CNT_W = $clog2(SPW);

   localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SPW - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

   capture_state_t              state_q, state_d;
   logic [CAPTURE_WORD_W-1:0]   shift_q, shift_d;
   logic [CNT_W-1:0]            smp_cnt_q, smp_cnt_d;
   logic [ADDR_W-1:0]           wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]             len_q, len_d;
   logic                        ring_q, ring_d;
   logic                        wrapped_q, wrapped_d;
   logic [ADDR_W-1:0]           rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]             rd_len_q, rd_len_d;
   logic [CAPTURE_WORD_W-1:0]   out_word_q, out_word_d;
   logic [1:0]                  byte_idx_q, byte_idx_d;

   logic [CW-1:0]               smp_pack;
   logic [CAPTURE_WORD_W-1:0]   word_nx;
   logic [CAPTURE_WORD_W-1:0]   rd_data;
   logic [ADDR_W:0]             cfg_eff;
   logic [ADDR_W-1:0]           wr_ptr_inc;
   logic [ADDR_W-1:0]           rd_ptr_inc;
   logic                        smp_take;
   logic                        word_done;

   // I occupies the low bits of each sample slot, Q sits directly above it.
   if (CHANNELS == 2) begin : g_iq
      assign smp_pack = {smp_q, smp_i};
   end else begin : g_i
      assign smp_pack = smp_i;
   end

   assign word_nx    = {smp_pack, shift_q[CAPTURE_WORD_W-1:CW]};
   assign smp_take   = (state_q == ST_CAPTURE) && smp_valid;
   assign word_done  = smp_take && (smp_cnt_q == CNT_LAST);
   assign wr_ptr_inc = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + ADDR_ONE;
   assign rd_ptr_inc = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + ADDR_ONE;
   assign cfg_eff    = ((cfg_words == '0) || (cfg_words > DEPTH_L)) ? DEPTH_L : cfg_words;

   // The completed word goes straight to RAM so a read issued next cycle sees it.
   capture_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .WIDTH  (CAPTURE_WORD_W)
   ) u_ram (
      .clk       (clk),
      .wr_en_i   (word_done),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (word_nx),
      .rd_en_i   (state_q == ST_RD_ADDR),
      .rd_addr_i (rd_ptr_q),
      .rd_data_o (rd_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         shift_q    <= '0;
         smp_cnt_q  <= '0;
         wr_ptr_q   <= '0;
         len_q      <= '0;
         ring_q     <= 1'b0;
         wrapped_q  <= 1'b0;
         rd_ptr_q   <= '0;
         rd_len_q   <= '0;
         out_word_q <= '0;
         byte_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         smp_cnt_q  <= smp_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         len_q      <= len_d;
         ring_q     <= ring_d;
         wrapped_q  <= wrapped_d;
         rd_ptr_q   <= rd_ptr_d;
         rd_len_q   <= rd_len_d;
         out_word_q <= out_word_d;
         byte_idx_q <= byte_idx_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      smp_cnt_d  = smp_cnt_q;
      wr_ptr_d   = wr_ptr_q;
      len_d      = len_q;
      ring_d     = ring_q;
      wrapped_d  = wrapped_q;
      rd_ptr_d   = rd_ptr_q;
      rd_len_d   = rd_len_q;
      out_word_d = out_word_q;
      byte_idx_d = byte_idx_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d   = ST_CAPTURE;
               shift_d   = '0;
               smp_cnt_d = '0;
               wr_ptr_d  = '0;
               wrapped_d = 1'b0;
               ring_d    = cfg_mode;
               len_d     = cfg_eff;
            end
         end

         ST_CAPTURE: begin
            if (smp_take) begin
               shift_d   = word_nx;
               smp_cnt_d = word_done ? '0 : smp_cnt_q + CNT_ONE;
            end
            if (word_done) begin
               wr_ptr_d = wr_ptr_inc;
               if (ring_q && (wr_ptr_q == LAST_ADDR)) begin
                  wrapped_d = 1'b1;
               end
            end
            if (!ring_q) begin
               if (word_done && ((ADDR_W+1)'(wr_ptr_q) + LEN_ONE == len_q)) begin
                  state_d  = ST_RD_ADDR;
                  rd_ptr_d = '0;
                  rd_len_d = len_q;
               end
            end else if (stop) begin
               // Uses the post-commit pointer so a word finishing this cycle is kept.
               rd_ptr_d = wrapped_d ? wr_ptr_d : '0;
               rd_len_d = wrapped_d ? DEPTH_L : (ADDR_W+1)'(wr_ptr_d);
               state_d  = (wrapped_d || (wr_ptr_d != '0)) ? ST_RD_ADDR : ST_DONE;
            end
         end

         ST_RD_ADDR: begin
            state_d = ST_RD_WAIT;
         end

         ST_RD_WAIT: begin
            out_word_d = rd_data;
            byte_idx_d = '0;
            state_d    = ST_SEND;
         end

         ST_SEND: begin
            if (out_ready) begin
               out_word_d = {8'h00, out_word_q[CAPTURE_WORD_W-1:8]};
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  rd_ptr_d = rd_ptr_inc;
                  rd_len_d = rd_len_q - LEN_ONE;
                  state_d  = (rd_len_q == LEN_ONE) ? ST_DONE : ST_RD_ADDR;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign out_data  = out_word_q[7:0];
   assign out_valid = (state_q == ST_SEND);
   assign out_last  = (state_q == ST_SEND) && (byte_idx_q == 2'd3) && (rd_len_q == LEN_ONE);
   assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign done      = (state_q == ST_DONE);
   assign wrapped   = wrapped_q;

endmodule
